// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART/ALU frame controller: FSM state encoding and ALU opcodes.
package uart_alu_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_GET_A   = 3'd0;
  localparam logic [STATE_W-1:0] ST_GET_B   = 3'd1;
  localparam logic [STATE_W-1:0] ST_GET_OP  = 3'd2;
  localparam logic [STATE_W-1:0] ST_EXEC    = 3'd3;
  localparam logic [STATE_W-1:0] ST_SEND    = 3'd4;
  localparam logic [STATE_W-1:0] ST_WAIT_TX = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    GET_A   = ST_GET_A,
    GET_B   = ST_GET_B,
    GET_OP  = ST_GET_OP,
    EXEC    = ST_EXEC,
    SEND    = ST_SEND,
    WAIT_TX = ST_WAIT_TX
  } state_t;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD = 6'h20;
  localparam logic [OP_W-1:0] OP_SUB = 6'h22;
  localparam logic [OP_W-1:0] OP_AND = 6'h24;
  localparam logic [OP_W-1:0] OP_OR  = 6'h25;
  localparam logic [OP_W-1:0] OP_XOR = 6'h26;
  localparam logic [OP_W-1:0] OP_SRA = 6'h03;
  localparam logic [OP_W-1:0] OP_SRL = 6'h02;
  localparam logic [OP_W-1:0] OP_NOR = 6'h27;

  // States in which an incoming byte is part of the frame being assembled.
  function automatic logic is_accepting(input state_t s);
    return (s == GET_A) || (s == GET_B) || (s == GET_OP);
  endfunction

endpackage

// File: rtl/uart_alu_frame_ctrl_timeout.sv
// Inter-byte idle counter: expire pulses combinationally on the TIMEOUT_CYCLES-th consecutive
// enabled cycle without clear; disabling or clearing restarts the count; 0 disables it.
module frame_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

      logic [CNT_W-1:0] cnt_q;

      // A byte on the expiry cycle suppresses expire, so the byte wins.
      assign expire = enable && !clear && (cnt_q == LAST);

      always_ff @(posedge clock) begin
        if (reset || clear || !enable || expire) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/uart_alu_frame_ctrl.sv
// Assembles A, B, opcode bytes into an ALU frame and sends the result; tx_start_o 2 cycles after opcode byte.
// No backpressure on rx: bytes arriving while a result is in flight are dropped and flagged on overrun_o.
module uart_alu_frame_ctrl
  import uart_alu_pkg::*;
#(
  parameter int N_BITS_DATA    = 8,
  parameter int N_BITS_OP      = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_BITS_DATA-1:0] rx_data_i,
  input  logic                   rx_done_i,
  input  logic                   tx_done_i,
  input  logic [N_BITS_DATA-1:0] alu_result_i,
  output logic [N_BITS_DATA-1:0] op_a_o,
  output logic [N_BITS_DATA-1:0] op_b_o,
  output logic [N_BITS_OP-1:0]   op_code_o,
  output logic [N_BITS_DATA-1:0] tx_data_o,
  output logic                   tx_start_o,
  output logic                   busy_o,
  output logic                   frame_err_o,
  output logic                   overrun_o
);

  state_t                 state_q, state_d;
  logic [N_BITS_DATA-1:0] op_a_q, op_a_d;
  logic [N_BITS_DATA-1:0] op_b_q, op_b_d;
  logic [N_BITS_OP-1:0]   op_code_q, op_code_d;
  logic [N_BITS_DATA-1:0] tx_data_q, tx_data_d;
  logic                   tx_start_q, tx_start_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;

  logic tmo_enable;
  logic tmo_expire;

  assign tmo_enable = (state_q == GET_B) || (state_q == GET_OP);

  frame_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .enable (tmo_enable),
    .clear  (rx_done_i),
    .expire (tmo_expire)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= GET_A;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_code_q   <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_code_q   <= op_code_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_code_d   = op_code_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = rx_done_i && !is_accepting(state_q);

    case (state_q)
      GET_A: begin
        if (rx_done_i) begin
          op_a_d  = rx_data_i;
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (rx_done_i) begin
          op_b_d  = rx_data_i;
          state_d = GET_OP;
        end else if (tmo_expire) begin
          frame_err_d = 1'b1;
          state_d     = GET_A;
        end
      end
      GET_OP: begin
        if (rx_done_i) begin
          op_code_d = rx_data_i[N_BITS_OP-1:0];
          state_d   = EXEC;
        end else if (tmo_expire) begin
          frame_err_d = 1'b1;
          state_d     = GET_A;
        end
      end
      // Operands have been registered for a full cycle, so the ALU output is settled here.
      EXEC: begin
        tx_data_d  = alu_result_i;
        tx_start_d = 1'b1;
        state_d    = SEND;
      end
      SEND: begin
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_done_i) begin
          state_d = GET_A;
        end
      end
      default: begin
        state_d = GET_A;
      end
    endcase
  end

  assign op_a_o      = op_a_q;
  assign op_b_o      = op_b_q;
  assign op_code_o   = op_code_q;
  assign tx_data_o   = tx_data_q;
  assign tx_start_o  = tx_start_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != GET_A);

endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// Randomised bench for uart_alu_frame_ctrl against a frame-level reference model and attached ALU.
module tb_uart_alu_frame_ctrl;

  localparam int W   = 8;
  localparam int OPW = 6;
  localparam int TMO = 16;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [W-1:0]   rx_data_i = '0;
  logic           rx_done_i = 1'b0;
  logic           tx_done_i = 1'b0;
  logic [W-1:0]   alu_result_i;
  logic [W-1:0]   op_a_o, op_b_o, tx_data_o;
  logic [OPW-1:0] op_code_o;
  logic           tx_start_o, busy_o, frame_err_o, overrun_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_tx     = 0;
  int exp_tx   = 0;

  localparam logic [OPW-1:0] OPS [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27};

  always #5 clock = ~clock;

  uart_alu_frame_ctrl #(
    .N_BITS_DATA    (W),
    .N_BITS_OP      (OPW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_data_i    (rx_data_i),
    .rx_done_i    (rx_done_i),
    .tx_done_i    (tx_done_i),
    .alu_result_i (alu_result_i),
    .op_a_o       (op_a_o),
    .op_b_o       (op_b_o),
    .op_code_o    (op_code_o),
    .tx_data_o    (tx_data_o),
    .tx_start_o   (tx_start_o),
    .busy_o       (busy_o),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o)
  );

  function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [OPW-1:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h03:   return W'($signed(a) >>> b);
      6'h02:   return a >> b;
      6'h27:   return ~(a | b);
      default: return '0;
    endcase
  endfunction

  assign alu_result_i = alu_ref(op_a_o, op_b_o, op_code_o);

  always @(negedge clock) begin
    if (tx_start_o) n_tx++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic send_byte(input logic [W-1:0] d);
    @(negedge clock);
    rx_data_i = d;
    rx_done_i = 1'b1;
    @(negedge clock);
    rx_done_i = 1'b0;
    rx_data_i = W'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_op_a"}, op_a_o, 0);
    check({tag, "_op_b"}, op_b_o, 0);
    check({tag, "_op_code"}, op_code_o, 0);
    check({tag, "_tx_data"}, tx_data_o, 0);
    check({tag, "_tx_start"}, tx_start_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_frame_err"}, frame_err_o, 0);
    check({tag, "_overrun"}, overrun_o, 0);
  endtask

  // One full frame: A, B, opcode bytes separated by gap idle cycles, then result and handshake.
  task automatic run_frame(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] opb,
                           input int gap, input bit early_done, input bit inject_ovr,
                           input bit rx_with_done, input int hold);
    logic [OPW-1:0] op;
    logic [W-1:0]   exp;
    op  = opb[OPW-1:0];
    exp = alu_ref(a, b, op);

    send_byte(a);
    check("op_a", op_a_o, a);
    check("busy_after_a", busy_o, 1);
    idle(gap);
    send_byte(b);
    check("op_b", op_b_o, b);
    check("no_frame_err_b", frame_err_o, 0);
    idle(gap);
    send_byte(opb);
    check("op_code", op_code_o, op);
    check("no_frame_err_op", frame_err_o, 0);
    check("tx_start_early", tx_start_o, 0);

    @(negedge clock);
    check("tx_start", tx_start_o, 1);
    check("tx_data", tx_data_o, exp);
    exp_tx++;
    if (early_done) tx_done_i = 1'b1;
    @(negedge clock);
    tx_done_i = 1'b0;
    check("tx_start_single", tx_start_o, 0);
    check("busy_wait_tx", busy_o, 1);

    if (inject_ovr) begin
      send_byte(W'($urandom));
      check("overrun", overrun_o, 1);
      check("busy_after_overrun", busy_o, 1);
    end
    idle(hold);
    check("tx_data_hold", tx_data_o, exp);

    @(negedge clock);
    tx_done_i = 1'b1;
    if (rx_with_done) begin
      rx_data_i = W'($urandom);
      rx_done_i = 1'b1;
    end
    @(negedge clock);
    tx_done_i = 1'b0;
    rx_done_i = 1'b0;
    check("busy_done", busy_o, 0);
    check("overrun_at_done", overrun_o, rx_with_done);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    idle(3);
    check_cleared("reset");
    reset = 1'b0;
    idle(2);

    run_frame(8'h05, 8'h03, 8'h20, 0, 1'b0, 1'b0, 1'b0, 2);
    run_frame(8'hF0, 8'h0F, 8'h25, 0, 1'b0, 1'b0, 1'b0, 0);

    // Silence after the first byte aborts the frame exactly TMO cycles later.
    send_byte(8'h11);
    check("tmo_start_err", frame_err_o, 0);
    for (int i = 2; i <= TMO; i++) begin
      @(negedge clock);
      check("tmo_not_yet", frame_err_o, 0);
    end
    @(negedge clock);
    check("tmo_frame_err", frame_err_o, 1);
    check("tmo_busy", busy_o, 0);
    check("tmo_keeps_a", op_a_o, 8'h11);
    @(negedge clock);
    check("tmo_pulse_end", frame_err_o, 0);
    run_frame(8'h02, 8'h02, 8'h22, 0, 1'b0, 1'b0, 1'b0, 1);

    // Bytes landing on the would-be expiry cycle are accepted.
    run_frame(8'h40, 8'h03, 8'h02, TMO - 2, 1'b0, 1'b0, 1'b0, 0);

    // tx_done in SEND is ignored; overrun in WAIT_TX is dropped.
    run_frame(8'h81, 8'h01, 8'h03, 1, 1'b1, 1'b1, 1'b0, 3);
    run_frame(8'h0C, 8'h0A, 8'h26, 2, 1'b0, 1'b0, 1'b1, 1);
    run_frame(8'h01, 8'h02, 8'hE0, 0, 1'b0, 1'b0, 1'b0, 0);

    // Reset in GET_OP, then reset in EXEC: neither may produce a tx_start.
    send_byte(8'h33);
    send_byte(8'h44);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_cleared("rst_get_op");
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h20);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_cleared("rst_exec");
    idle(3);
    check("rst_no_start", tx_start_o, 0);
    run_frame(8'h07, 8'h09, 8'h24, 0, 1'b0, 1'b0, 1'b0, 0);

    for (int k = 0; k < 25; k++) begin
      logic [W-1:0] opb;
      opb = {2'($urandom), OPS[$urandom_range(0, 7)]};
      run_frame(W'($urandom), W'($urandom_range(0, 9)), opb, $urandom_range(0, TMO - 2),
                1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 4));
    end

    idle(2);
    check("tx_start_count", n_tx, exp_tx);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
